// File: rtl/apb_pkg.sv
// Shared definitions for the APB register-bank slave.
//   apb_state_e : FSM states (IDLE, WAIT, ACCESS)
//   strb_w()    : number of byte strobes for a given data width
//   idx_lsb()   : number of byte-offset address bits for a given data width
//   strb_merge(): byte-enabled merge of write data into an existing word
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // Merge helpers work at the widest legal data width; callers cast down.
    localparam int unsigned MAX_DATA_W = 32;
    localparam int unsigned MAX_STRB_W = MAX_DATA_W / 8;

    function automatic int unsigned strb_w(input int unsigned data_w);
        return data_w / 8;
    endfunction

    function automatic int unsigned idx_lsb(input int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

    // Bytes whose strobe is set come from new_val, the rest from old_val.
    function automatic logic [MAX_DATA_W-1:0] strb_merge(
        input logic [MAX_DATA_W-1:0] old_val,
        input logic [MAX_DATA_W-1:0] new_val,
        input logic [MAX_STRB_W-1:0] strb
    );
        logic [MAX_DATA_W-1:0] res;
        res = old_val;
        for (int b = 0; b < int'(MAX_STRB_W); b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/apb_regfile.sv
// DEPTH x DATA_W register storage with one byte-enabled write port and one
// combinational read port. Out-of-range indices write nothing and read 0.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset (loads RESET_VAL)
//   we, widx        : write enable and word index
//   wdata, wstrb    : write data and byte strobes
//   ridx, rdata     : read word index and combinational read data
module apb_regfile
    import apb_pkg::*;
#(
    parameter int unsigned         DATA_W    = 32,
    parameter int unsigned         DEPTH     = 16,
    parameter int unsigned         IDX_W     = 6,
    parameter logic [DATA_W-1:0]   RESET_VAL = '0,
    localparam int unsigned        STRB_W    = strb_w(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic [IDX_W-1:0]  ridx,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned MEM_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic                 w_in_range;
    logic                 r_in_range;
    logic [MEM_IDX_W-1:0] w_mem_idx;
    logic [MEM_IDX_W-1:0] r_mem_idx;
    logic [DATA_W-1:0]    w_merged;

    assign w_in_range = (32'(widx) < DEPTH);
    assign r_in_range = (32'(ridx) < DEPTH);
    assign w_mem_idx  = MEM_IDX_W'(widx);
    assign r_mem_idx  = MEM_IDX_W'(ridx);
    assign w_merged   = DATA_W'(strb_merge(MAX_DATA_W'(mem[w_mem_idx]),
                                           MAX_DATA_W'(wdata),
                                           MAX_STRB_W'(wstrb)));

    // Storage with byte-enabled write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= RESET_VAL;
            end
        end else if (we && w_in_range) begin
            mem[w_mem_idx] <= w_merged;
        end
    end

    // Combinational read port.
    assign rdata = r_in_range ? mem[r_mem_idx] : '0;

endmodule

// File: rtl/apb_slave_regbank.sv
// Parametrised APB slave register bank with wait states, byte strobes and
// error response on out-of-range or misaligned addresses.
// Ports:
//   pclk, rst                      : clock, asynchronous active-high reset
//   paddr, psel, penable, pwrite   : APB request
//   pwdata, pstrb                  : write data and byte strobes
//   pready, prdata, pslverr        : registered APB response
module apb_slave_regbank
    import apb_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 8,
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       DEPTH       = 16,
    parameter int unsigned       WAIT_STATES = 0,
    parameter logic [DATA_W-1:0] RESET_VAL   = '0,
    localparam int unsigned      STRB_W      = strb_w(DATA_W)
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] paddr,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [DATA_W-1:0] pwdata,
    input  logic [STRB_W-1:0] pstrb,
    output logic              pready,
    output logic [DATA_W-1:0] prdata,
    output logic              pslverr
);

    localparam int unsigned IDX_LSB = idx_lsb(DATA_W);
    localparam int unsigned IDX_W   = ADDR_W - IDX_LSB;
    localparam int unsigned CNT_W   = 4;

    apb_state_e state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;

    // Latched setup-phase request.
    logic [IDX_W-1:0]  idx_q;
    logic              wr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] strb_q;
    logic              err_q;

    logic              pready_nxt;
    logic [DATA_W-1:0] prdata_nxt;
    logic              pslverr_nxt;

    logic              capture_c;
    logic [IDX_W-1:0]  cap_idx_c;
    logic              cap_err_c;
    logic              commit_c;
    logic [IDX_W-1:0]  acc_idx_c;
    logic              acc_wr_c;
    logic              acc_err_c;
    logic [DATA_W-1:0] rdata_c;
    logic [DATA_W-1:0] rd_val_c;

    // Setup decode: a setup phase is accepted only from IDLE or ACCESS.
    assign capture_c = psel && !penable && (state == IDLE || state == ACCESS);
    assign cap_idx_c = IDX_W'(paddr >> IDX_LSB);
    assign cap_err_c = (32'(cap_idx_c) >= DEPTH) ||
                       ((paddr & ADDR_W'((1 << IDX_LSB) - 1)) != '0);

    // Write lands on the edge that ends ACCESS.
    assign commit_c  = (state == ACCESS) && wr_q && !err_q;

    // Request that will own the next ACCESS cycle.
    assign acc_idx_c = capture_c ? cap_idx_c : idx_q;
    assign acc_wr_c  = capture_c ? pwrite    : wr_q;
    assign acc_err_c = capture_c ? cap_err_c : err_q;

    // A read captured on the same edge a write to that word commits sees the new data.
    assign rd_val_c = (commit_c && acc_idx_c == idx_q)
                    ? DATA_W'(strb_merge(MAX_DATA_W'(rdata_c), MAX_DATA_W'(wdata_q),
                                         MAX_STRB_W'(strb_q)))
                    : rdata_c;

    apb_regfile #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .IDX_W     (IDX_W),
        .RESET_VAL (RESET_VAL)
    ) u_regfile (
        .clk   (pclk),
        .rst   (rst),
        .we    (commit_c),
        .widx  (idx_q),
        .wdata (wdata_q),
        .wstrb (strb_q),
        .ridx  (acc_idx_c),
        .rdata (rdata_c)
    );

    // State, counter and registered response.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            pready  <= 1'b0;
            prdata  <= '0;
            pslverr <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pready  <= pready_nxt;
            prdata  <= prdata_nxt;
            pslverr <= pslverr_nxt;
        end
    end

    // Setup-phase request latch.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            err_q   <= 1'b0;
        end else if (capture_c) begin
            idx_q   <= cap_idx_c;
            wr_q    <= pwrite;
            wdata_q <= pwdata;
            strb_q  <= pstrb;
            err_q   <= cap_err_c;
        end
    end

    // Next-state and response decode.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pready_nxt  = 1'b0;
        prdata_nxt  = '0;
        pslverr_nxt = 1'b0;

        case (state)
            IDLE, ACCESS: begin
                state_nxt = IDLE;
                if (capture_c) begin
                    if (WAIT_STATES == 0) begin
                        state_nxt = ACCESS;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_W'(WAIT_STATES - 1);
                    end
                end
            end
            WAIT: begin
                if (!psel) begin
                    state_nxt = IDLE;
                end else if (cnt == '0) begin
                    state_nxt = ACCESS;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (state_nxt == ACCESS) begin
            pready_nxt  = 1'b1;
            pslverr_nxt = acc_err_c;
            if (!acc_wr_c && !acc_err_c) begin
                prdata_nxt = rd_val_c;
            end
        end
    end

endmodule
